// File: rtl/shift_right_pkg.sv
// Shared constants, fill-mode enum and overflow helper for the shift_right slice.
package shift_right_pkg;

  localparam int SHIFT_RIGHT_DEFAULT_N = 8;

  typedef enum logic {
    SHIFT_LOGICAL = 1'b0,
    SHIFT_ARITH   = 1'b1
  } shift_mode_e;

  // Callers pass only the shift-amount bits that fit in 32 bits.
  function automatic logic shamt_overflow(input logic [31:0] b, input int unsigned n);
    return (b >= n);
  endfunction

endpackage

// File: rtl/shift_right_if.sv
// Operand/result bundle for shift_right; the arith select exists only with SHIFT_RIGHT_ARITH_EN.
interface shift_right_if import shift_right_pkg::*; #(
    parameter int N = SHIFT_RIGHT_DEFAULT_N
);
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef SHIFT_RIGHT_ARITH_EN
    logic         arith;
`endif
    logic [N-1:0] result;

`ifdef SHIFT_RIGHT_ARITH_EN
    modport master (output a, b, arith, input result);
    modport slave  (input a, b, arith, output result);
`else
    modport master (output a, b, input result);
    modport slave  (input a, b, output result);
`endif
endinterface

// File: rtl/shift_right_barrel.sv
// Combinational log2-stage right barrel shifter with a caller-supplied fill bit.
module shift_right_barrel import shift_right_pkg::*; #(
    parameter int N = SHIFT_RIGHT_DEFAULT_N
) (
    input  logic [N-1:0] data,
    input  logic [N-1:0] shamt,
    input  logic         fill,
    output logic [N-1:0] out
);
    localparam int S = $clog2(N);

    logic [S:0][N-1:0] st;
    logic              ovf;

    assign st[0] = data;

    genvar k;
    generate
        for (k = 0; k < S; k++) begin : g_stage
            localparam int SH = 1 << k;
            assign st[k+1] = shamt[k] ? {{SH{fill}}, st[k][N-1:SH]} : st[k];
        end
    endgenerate

    // Upper bits catch large amounts; the low-field compare catches non-power-of-2 widths.
    assign ovf = (|shamt[N-1:S]) | shamt_overflow(32'(shamt[S-1:0]), N);
    assign out = ovf ? {N{fill}} : st[S];

endmodule

// File: rtl/shift_right.sv
// Registered right shifter, one-cycle latency, async active-low reset.
// Define SHIFT_RIGHT_ARITH_EN to add the arith (sign-fill) select.
module shift_right import shift_right_pkg::*; #(
    parameter int N = SHIFT_RIGHT_DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_right_if.slave   bus
);
    shift_mode_e  mode;
    logic         fill;
    logic [N-1:0] nxt;

`ifdef SHIFT_RIGHT_ARITH_EN
    assign mode = bus.arith ? SHIFT_ARITH : SHIFT_LOGICAL;
`else
    assign mode = SHIFT_LOGICAL;
`endif
    assign fill = (mode == SHIFT_ARITH) ? bus.a[N-1] : 1'b0;

    shift_right_barrel #(.N(N)) u_barrel (
        .data  (bus.a),
        .shamt (bus.b),
        .fill  (fill),
        .out   (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.result <= '0;
        else        bus.result <= nxt;
    end

endmodule

// File: tb/tb_shift_right.sv
// Self-checking bench for shift_right: vector table, sweep, reset sequence and an N=16 instance.
module tb_shift_right;
    import shift_right_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ar;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nbad = 0;
    logic [7:0]  q8[$];
    logic [15:0] q16[$];
    vec_t tbl[$];

    shift_right_if #(.N(8))  bus8 ();
    shift_right_if #(.N(16)) bus16 ();

    shift_right #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    shift_right #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Per-bit reference: result bit i takes a[i+b] or the fill bit.
    function automatic logic [7:0] model8(logic [7:0] a, logic [7:0] b, logic ar);
        logic [7:0] r;
        logic fill = ar & a[7];
        for (int i = 0; i < 8; i++) begin
            int src = i + int'(b);
            r[i] = (src < 8) ? a[src] : fill;
        end
        return r;
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ar, input logic [7:0] exp);
        @(negedge clk);
        bus8.a = a;
        bus8.b = b;
`ifdef SHIFT_RIGHT_ARITH_EN
        bus8.arith = ar;
`endif
        q8.push_back(exp);
    endtask

    task automatic sample8(input string nm);
        @(posedge clk);
        #1;
        if (q8.size() == 0) begin
            nvec++; nbad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            check(nm, 16'(bus8.result), 16'(q8.pop_front()));
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ar, input logic [15:0] exp, input string nm);
        @(negedge clk);
        bus16.a = a;
        bus16.b = b;
`ifdef SHIFT_RIGHT_ARITH_EN
        bus16.arith = ar;
`endif
        q16.push_back(exp);
        @(posedge clk);
        #1;
        check(nm, bus16.result, q16.pop_front());
    endtask

    initial begin
        bus8.a = '0; bus8.b = '0; bus16.a = '0; bus16.b = '0;
`ifdef SHIFT_RIGHT_ARITH_EN
        bus8.arith = 1'b0; bus16.arith = 1'b0;
`endif
        tbl.push_back('{8'h96, 8'h02, 1'b0, 8'h25});
        tbl.push_back('{8'h96, 8'h00, 1'b0, 8'h96});
        tbl.push_back('{8'h96, 8'h07, 1'b0, 8'h01});
        tbl.push_back('{8'hFF, 8'h08, 1'b0, 8'h00});
        tbl.push_back('{8'hFF, 8'h10, 1'b0, 8'h00});
        tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'h00});
        tbl.push_back('{8'h80, 8'h07, 1'b0, 8'h01});
        tbl.push_back('{8'h3C, 8'h03, 1'b0, 8'h07});
        tbl.push_back('{8'h96, 8'h02, 1'b1, 8'hE5});
        tbl.push_back('{8'h96, 8'h09, 1'b1, 8'hFF});
        tbl.push_back('{8'h46, 8'h02, 1'b1, 8'h11});
        tbl.push_back('{8'h96, 8'hFF, 1'b1, 8'hFF});
        tbl.push_back('{8'h7F, 8'hFF, 1'b1, 8'h00});
        tbl.push_back('{8'h96, 8'h00, 1'b1, 8'h96});

        #3;
        check("reset8", 16'(bus8.result), 16'h0000);
        check("reset16", bus16.result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
`ifndef SHIFT_RIGHT_ARITH_EN
            if (tbl[i].ar) continue;
`endif
            drive8(tbl[i].a, tbl[i].b, tbl[i].ar, tbl[i].exp);
            sample8($sformatf("vec%0d", i));
        end

        // Back-to-back sweep, one result per cycle.
        for (int s = 0; s <= 8; s++) begin
            logic [7:0] sw [0:8];
            sw = '{8'hA5, 8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
            drive8(8'hA5, 8'(s), 1'b0, sw[s]);
            sample8($sformatf("sweep_b%0d", s));
        end

        for (int r = 0; r < 24; r++) begin
            logic [7:0] ra, rb;
            logic rar;
            ra  = 8'($urandom);
            rb  = (r % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
`ifdef SHIFT_RIGHT_ARITH_EN
            rar = 1'($urandom);
`else
            rar = 1'b0;
`endif
            drive8(ra, rb, rar, model8(ra, rb, rar));
            sample8($sformatf("rand%0d", r));
        end

        // Async reset mid-cycle, then recapture on release.
        drive8(8'hF0, 8'h01, 1'b0, 8'h78);
        sample8("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'(bus8.result), 16'h0000);
        @(posedge clk);
        #1;
        check("reset_hold", 16'(bus8.result), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 16'(bus8.result), 16'h0078);

        run16(16'h8001, 16'd15, 1'b0, 16'h0001, "n16_b15");
        run16(16'h8001, 16'd16, 1'b0, 16'h0000, "n16_b16");
        run16(16'h8001, 16'h8000, 1'b0, 16'h0000, "n16_bhi");
        run16(16'hF00F, 16'd4, 1'b0, 16'h0F00, "n16_b4");
`ifdef SHIFT_RIGHT_ARITH_EN
        run16(16'h8001, 16'd15, 1'b1, 16'hFFFF, "n16_arith_b15");
        run16(16'h8001, 16'd20, 1'b1, 16'hFFFF, "n16_arith_b20");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/shift_right.md
# shift_right

Registered, parameterised logical right shifter. Each rising clock edge samples operand `a` and shift amount `b` and registers `a` shifted right by `b` bit positions, zero-filled. The shift is built as a log2-stage barrel shifter. It is a leaf datapath block used as the shift unit next to the ALU.

## Interface
- `N`, default 8: data width in bits for `a`, `b` and `result`; legal values are N ≥ 2.
- One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `a`  input  N  operand to be shifted.
- `b`  input  N  unsigned shift amount; the full N-bit value is significant.
- `arith`  input  1  arithmetic-shift select; present only when `SHIFT_RIGHT_ARITH_EN` is defined.
- `result`  output  N  registered shift result.

## Operation
- Logical mode:
  - result_next = a >> b; vacated MSBs are filled with 0.
  - b = 0 passes `a` through unchanged.
  - Any b ≥ N gives all zeros. This covers upper bits of `b` set and b = 2^N−1.
- Barrel structure:
  - Stages k = 0..S−1, where S = $clog2(N).
  - Stage k shifts by 2^k when bit k of `b` is set.
  - An overflow detect (any bit of `b` at index ≥ S set, or b ≥ N) forces the fill value on all N bits.
- No state beyond the output register. No handshake; the block computes on every cycle.
- Inputs are treated as unsigned except in arithmetic mode, where the fill bit is a[N−1].

## Timing
- Latency is exactly 1 cycle. Values of `a` and `b` at rising edge t appear on `result` after edge t and stay stable until edge t+1.
- Throughput is one result per cycle. Back-to-back input changes each produce their own result.
- Reset:
  - `rst_n` low clears `result` to 0 immediately, without waiting for a clock edge.
  - While `rst_n` is low, `result` holds 0.
  - The first edge after `rst_n` rises captures the current inputs normally.
  - Reset asserted mid-stream discards the pending value; no stale result appears after release.
- Inputs changing between edges have no effect on `result` until the next edge. The combinational path is internal only.

## Configuration
- `SHIFT_RIGHT_ARITH_EN` defined:
  - The `arith` port exists.
  - arith=1 selects sign fill (a[N−1]) for vacated bits, including the b ≥ N case, which gives all copies of a[N−1].
  - arith=0 behaves exactly as logical mode.
- Macro undefined: no `arith` port, and the block is purely logical with zero fill.

## Structure
- Package `shift_right_pkg`:
  - `SHIFT_RIGHT_DEFAULT_N = 8`.
  - An enum `shift_mode_e {SHIFT_LOGICAL, SHIFT_ARITH}` used internally for fill selection.
  - A function `shamt_overflow(b, n)` returning 1 when b ≥ n.
- Sub-module `shift_right_barrel`:
  - Purely combinational and parameterised by N.
  - Inputs: data, shift amount, fill bit.
  - Output: shifted data, built with a generate loop over the S stages.
- Top level instantiates the barrel and holds the output register with async reset.

## Test plan
- N=8, a=0x96, b=0x02, one edge → `result`=0x25. Check 0x96 with b=0 → 0x96, and b=7 → 0x01.
- Out-of-range shift amounts:
  - a=0xFF, b=0x08 → 0x00.
  - b=0x10 → 0x00.
  - b=0xFF → 0x00. This covers the upper-bit overflow path.
- Sweep a=0xA5 with b=0..8 on consecutive cycles → 0xA5, 0x52, 0x29, 0x14, 0x0A, 0x05, 0x02, 0x01, 0x00, each one cycle after its input.
- Reset behaviour:
  - Drive a=0xF0, b=1 and let `result`=0x78.
  - Drop `rst_n` mid-cycle → `result`=0x00 at once, with no clock edge.
  - Release `rst_n` → the next edge gives 0x78.
- With `SHIFT_RIGHT_ARITH_EN`:
  - a=0x96, b=2, arith=1 → 0xE5.
  - b=9, arith=1 → 0xFF.
  - a=0x46, b=2, arith=1 → 0x11.
  - arith=0 → same values as the logical cases.
- N=16 instance:
  - a=0x8001, b=15 → 0x0001.
  - b=16 → 0x0000.
